load_align_unit: RTL
====================

# load_align_unit

Parametrised load path between the core's memory stage and the data-memory port. Accepts one load per transaction (byte, half, word and, at 64-bit width, double; signed or unsigned) and issues aligned bus reads. Misaligned accesses spanning two bus words are split into two reads, merged, then shifted and extended. Returns a single registered writeback beat tagged with the destination register.

## Interface
Parameters:
- DWIDTH, 32, data bus and result width in bits; 32 or 64.
- AWIDTH, 32, byte-address width.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  load request present
- req_ready  out  1  high only in IDLE with rst low
- req_addr  in  AWIDTH  byte address
- req_func3  in  3  load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- req_rd  in  5  destination tag, returned unchanged
- mem_req_valid  out  1  bus read request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  AWIDTH  aligned read address; low log2(DWIDTH/8) bits always 0
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  DWIDTH  read data, little-endian byte lanes
- rsp_valid  out  1  one-cycle writeback pulse; no backpressure
- rsp_data  out  DWIDTH  aligned, extended load result
- rsp_rd  out  5  tag of the completing load
- rsp_fault  out  1  high with rsp_valid for illegal or unsupported access

## Operation
- LANES = DWIDTH/8. off = req_addr mod LANES. size = 1 << func3[1:0]. unsigned = func3[2].
- Illegal func3:
  - 111 always;
  - 011 and 110 when DWIDTH=32;
  - 111 and 011 with bit 2 set are the same code.
- split = (off + size > LANES).
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on req_valid & req_ready, latch addr, func3 and rd.
  - Illegal func3 -> RESP with fault.
  - Otherwise -> REQ0.
- REQ0: mem_req_valid=1, mem_req_addr = addr with low bits cleared. Hold until mem_req_ready, then -> WAIT0.
- WAIT0: on mem_resp_valid, capture lo = mem_resp_data. Go to REQ1 if split, else RESP.
- REQ1: mem_req_valid=1, mem_req_addr = aligned addr + LANES; the address wraps modulo 2^AWIDTH. On mem_req_ready -> WAIT1.
- WAIT1: on mem_resp_valid, capture hi -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
  - Result: w = {hi, lo} >> (8*off). Keep the low 8*size bits of w.
  - Zero-extend if unsigned, else sign-extend from bit 8*size-1.
  - Faulting load: rsp_data=0, rsp_fault=1. Otherwise rsp_fault=0.
- hi is don't-care and not used when the access is not split.
- mem_resp_valid outside WAIT0/WAIT1 is ignored.
- mem_req_valid and mem_req_addr stay stable from assertion until accepted.
- rsp_data, rsp_rd and rsp_fault are registered and hold their value after the pulse until the next RESP.

## Timing
- Reset: state IDLE; req_ready, mem_req_valid, rsp_valid, rsp_fault = 0; mem_req_addr, rsp_data, rsp_rd = 0.
- rst asserted mid-transaction aborts immediately and returns to IDLE. Any outstanding bus response after release is ignored.
- Aligned load, mem_req_ready=1, response one cycle after acceptance: handshake at T, bus request accepted at T+1, data at T+2, rsp_valid at T+3.
- Split load: rsp_valid at T+5 under the same bus conditions.
- Fault: rsp_valid at T+1; no bus request is issued.
- Each bus wait stall adds one cycle per stall cycle.
- Back-to-back: req_ready rises the cycle after RESP, so the peak rate is one aligned load per 4 cycles.

## Configuration
- LOAD_MISALIGN_SPLIT_EN defined: split accesses perform two reads as described.
- Not defined: REQ1 and WAIT1 are not implemented. A split access is treated as a fault: IDLE -> RESP with rsp_fault=1, rsp_data=0, and no bus request.
- Aligned and in-word misaligned accesses behave identically in both builds.

## Test plan
- DWIDTH=32, LB at 0x1003, memory word 0x80FF_1234 -> rsp_data 0xFFFF_FF80, rsp_fault 0, rsp_valid at T+3.
- LHU at 0x1002, word 0x80FF_1234 -> 0x0000_80FF. LH at the same address -> 0xFFFF_80FF.
- Split enabled, LW at 0x1003, words 0x1122_3344 @0x1000 and 0x5566_7788 @0x1004:
  - reads issued to 0x1000 then 0x1004;
  - rsp_data 0x6677_8811 at T+5.
- Split disabled, same LW at 0x1003 -> rsp_fault 1, rsp_data 0, mem_req_valid never asserted.
- func3=011 with DWIDTH=32 -> fault at T+1. With DWIDTH=64, LD at 0x8 returns the full 64-bit word.
- Bus stalls of 3 cycles on mem_req_ready, plus rst pulsed while in WAIT0 -> FSM returns to IDLE with all outputs 0. A late mem_resp_valid is ignored, and the next LW completes correctly.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: load path between the memory stage and the data-memory port.
// Issues aligned bus reads for byte/half/word (and double at DWIDTH=64) loads,
// then shifts and sign/zero-extends the result and returns one registered
// writeback beat tagged with the destination register.
//
// Optional feature macro: LOAD_MISALIGN_SPLIT_EN
//   defined     - loads that cross a bus word are split into two reads and merged
//   not defined - loads that cross a bus word fault without touching the bus
module load_align_unit #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AWIDTH-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DWIDTH-1:0] mem_resp_data,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault
);

    localparam int LANES = DWIDTH / 8;
    localparam int OFFW  = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    // 111 is never a load; doubles and LWU only exist on a 64-bit bus.
    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3 == 3'b111) ||
               ((DWIDTH == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    // True when the access runs past the end of the bus word it starts in.
    function automatic logic is_split(input logic [OFFW-1:0] off, input logic [1:0] size_code);
        logic [4:0] span;
        span = 5'(off) + (5'd1 << size_code);
        return span > 5'(LANES);
    endfunction

    // Shift the merged {hi, lo} pair down to the addressed byte, keep the
    // access width and extend it to the full result width.
    function automatic logic [DWIDTH-1:0] align_extend(input logic [2*DWIDTH-1:0] w,
                                                       input logic [OFFW-1:0]     off,
                                                       input logic [2:0]          f3);
        logic [DWIDTH-1:0] low;
        logic [DWIDTH-1:0] mask;
        logic              sgn;
        low = DWIDTH'(w >> {off, 3'b000});
        case (f3[1:0])
            2'b00: begin
                mask = DWIDTH'(8'hFF);
                sgn  = low[7];
            end
            2'b01: begin
                mask = DWIDTH'(16'hFFFF);
                sgn  = low[15];
            end
            2'b10: begin
                mask = DWIDTH'(32'hFFFF_FFFF);
                sgn  = low[31];
            end
            default: begin
                mask = '1;
                sgn  = low[DWIDTH-1];
            end
        endcase
        return (low & mask) | ((sgn && !f3[2]) ? ~mask : '0);
    endfunction

    state_t              state_q, state_d;
    logic [OFFW-1:0]     off_q, off_d;
    logic [2:0]          func3_q, func3_d;
    logic [4:0]          rd_q, rd_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [AWIDTH-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [4:0]          rsp_rd_q, rsp_rd_d;
    logic                rsp_fault_q, rsp_fault_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic [DWIDTH-1:0]   lo_q, lo_d;
`endif

    logic                req_fault_s;
    logic                complete_s;
    logic [2*DWIDTH-1:0] merged_s;

    // Request-side fault decision and the {hi, lo} pair feeding the aligner.
    always_comb begin
`ifdef LOAD_MISALIGN_SPLIT_EN
        req_fault_s = is_illegal(req_func3);
        merged_s    = (state_q == WAIT1) ? {mem_resp_data, lo_q}
                                         : {{DWIDTH{1'b0}}, mem_resp_data};
`else
        req_fault_s = is_illegal(req_func3) ||
                      is_split(req_addr[OFFW-1:0], req_func3[1:0]);
        merged_s    = {{DWIDTH{1'b0}}, mem_resp_data};
`endif
    end

    // Next-state and next-output logic for the load sequencer.
    always_comb begin
        state_d         = state_q;
        off_d           = off_q;
        func3_d         = func3_q;
        rd_d            = rd_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = rsp_data_q;
        rsp_rd_d        = rsp_rd_q;
        rsp_fault_d     = rsp_fault_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
        lo_d            = lo_q;
`endif
        complete_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[OFFW-1:0];
                    func3_d = req_func3;
                    rd_d    = req_rd;
                    if (req_fault_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_rd_d    = req_rd;
                    end else begin
                        state_d         = REQ0;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = req_addr & ~AWIDTH'(LANES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ0: begin
                if (mem_req_ready) begin
                    state_d         = WAIT0;
                    mem_req_valid_d = 1'b0;
                end else begin
                    state_d = REQ0;
                end
            end
            WAIT0: begin
                if (mem_resp_valid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    if (is_split(off_q, func3_q[1:0])) begin
                        lo_d            = mem_resp_data;
                        state_d         = REQ1;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = mem_req_addr_q + AWIDTH'(LANES);
                    end else begin
                        complete_s = 1'b1;
                    end
`else
                    complete_s = 1'b1;
`endif
                end else begin
                    state_d = WAIT0;
                end
            end
`ifdef LOAD_MISALIGN_SPLIT_EN
            REQ1: begin
                if (mem_req_ready) begin
                    state_d         = WAIT1;
                    mem_req_valid_d = 1'b0;
                end else begin
                    state_d = REQ1;
                end
            end
            WAIT1: begin
                if (mem_resp_valid) begin
                    complete_s = 1'b1;
                end else begin
                    state_d = WAIT1;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d         = IDLE;
                mem_req_valid_d = 1'b0;
            end
        endcase

        if (complete_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_data_d  = align_extend(merged_s, off_q, func3_q);
            rsp_rd_d    = rd_q;
        end else begin
            rsp_valid_d = rsp_valid_d;
        end
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            off_q           <= '0;
            func3_q         <= 3'b000;
            rd_q            <= 5'd0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_rd_q        <= 5'd0;
            rsp_fault_q     <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            lo_q            <= '0;
`endif
        end else begin
            state_q         <= state_d;
            off_q           <= off_d;
            func3_q         <= func3_d;
            rd_q            <= rd_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_rd_q        <= rsp_rd_d;
            rsp_fault_q     <= rsp_fault_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
            lo_q            <= lo_d;
`endif
        end
    end

    // Ready is qualified by rst so it is low throughout reset.
    assign req_ready     = (state_q == IDLE) && !rst;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_rd        = rsp_rd_q;
    assign rsp_fault     = rsp_fault_q;

endmodule
